instr_fetcher: RTL and testbench
================================

// Module: instr_fetcher
// PURPOSE
//  Front-end fetch unit feeding the Decoder. Holds the PC and fetches 32-bit instructions.
//  Fetches come from a direct-mapped instruction cache, or from the memory controller on a miss.
//  Presents one instruction at a time (instr_ready/instr_in/instr_addr_in) until the Decoder issues it.
//  On issue, advances to the Decoder's predict_pc. The RoB redirects the PC on misprediction (rob_clear).
// PARAMETERS
//  RESET_PC      32'h0  PC loaded on reset
//  ICACHE_IDX_W  4      log2(cache lines); one 32-bit word per line
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   synchronous reset, active-low (0 = reset), sampled on posedge clk
//  rdy            in   1   global enable; 0 = hold all state
//  instr_issued   in   1   Decoder accepted the presented instruction this cycle
//  predict_pc     in   32  Decoder's next-PC prediction for the presented instruction
//  instr_ready    out  1   instr_in/instr_addr_in valid
//  instr_in       out  32  instruction word
//  instr_addr_in  out  32  address of instr_in
//  mem_req        out  1   fetch request to memory controller
//  mem_addr       out  32  word address of the fetch; stable while mem_req=1
//  mem_done       in   1   1-cycle pulse: mem_data valid for the current request
//  mem_data       in   32  fetched instruction word
//  rob_clear      in   1   flush/redirect from RoB
//  rob_new_pc     in   32  redirect target
// BEHAVIOUR
//  Reset (rst=0 at posedge): pc=RESET_PC, state=IDLE, all cache valid bits=0.
//   Reset also forces instr_ready=0, instr_in=0, instr_addr_in=0, mem_req=0, mem_addr=0.
//  Priority: rst > rdy=0 (freeze) > rob_clear > normal operation.
//  pc[1:0] treated as 0. Cache index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
//  Hit = valid[idx] && tag matches.
//  States:
//   IDLE: on a hit, next cycle instr_ready=1 with cached word and instr_addr_in=pc; go to HOLD.
//     On a miss, assert mem_req=1 with mem_addr=pc; go to WAIT_MEM.
//   WAIT_MEM: keep mem_req and mem_addr stable until mem_done.
//     On mem_done: write line {valid=1, tag, mem_data}, set mem_req=0, present mem_data
//     (instr_ready=1, instr_addr_in=pc); go to HOLD.
//   HOLD: instr_ready, instr_in and instr_addr_in stay stable while instr_issued=0.
//     On instr_issued: pc<=predict_pc.
//     If predict_pc hits, present that word next cycle and stay in HOLD
//       (one instruction per cycle throughput).
//     Otherwise set instr_ready=0, mem_req=1, mem_addr=predict_pc; go to WAIT_MEM.
//   DROP: an outstanding request was flushed. Keep mem_req until mem_done.
//     The response fills the cache but is never presented; then go to IDLE.
//  rob_clear (any state): pc<=rob_new_pc, instr_ready<=0.
//   From WAIT_MEM go to DROP; from DROP stay in DROP; from any other state go to IDLE.
//   rob_clear overrides a simultaneous instr_issued (predict_pc ignored).
//   If rob_clear coincides with mem_done in WAIT_MEM or DROP: fill the cache, go to IDLE,
//   do not present the word.
//  Latency: hit = 1 cycle from IDLE; miss = 1 cycle after mem_done.
//  Minimum gap between issues = 0 cycles on consecutive hits.
//  Only one memory request outstanding at a time. No cache writes other than fetch fills.
// TESTING
//  1 rst=0 for 2 cycles, RESET_PC=0, memory returns 32'h00000013 for addr 0 after 3 cycles
//    -> mem_req=1 with mem_addr=0; instr_ready=1, instr_in=0x13, instr_addr_in=0
//    the cycle after mem_done.
//  2 addrs 0x0 and 0x4 cached; Decoder issues every cycle with predict_pc alternating 0x4/0x0
//    -> instr_ready held at 1, instr_addr_in toggles 0x0/0x4 each cycle, mem_req stays 0.
//  3 HOLD with instr_issued=0 for 5 cycles -> instr_in/instr_addr_in unchanged, no mem_req;
//    then issue with predict_pc=0x8 (miss) -> mem_req=1, mem_addr=0x8 next cycle.
//  4 rob_clear with rob_new_pc=0x100 while waiting on 0x8
//    -> 0x8 response never presented (instr_ready stays 0); cache now holds 0x8;
//    next mem_req has mem_addr=0x100.
//  5 IDX_W=4: fetch 0x0, then 0x40 (same index), then 0x0 again -> all three are misses;
//    mem_req issued each time.
//  6 rdy=0 for 4 cycles mid-WAIT_MEM (mem_done held off) -> no state or output change;
//    with rst=0 mid-HOLD -> next cycle instr_ready=0, pc=RESET_PC, all lines invalid.

Source files
------------

// File: rtl/instr_fetcher_if.sv
// rtl/instr_fetcher_if.sv - fetch-unit bus: decoder handshake, memory fetch port and RoB redirect
interface instr_fetcher_if;
    logic        instr_issued;
    logic [31:0] predict_pc;
    logic        instr_ready;
    logic [31:0] instr_in;
    logic [31:0] instr_addr_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        rob_clear;
    logic [31:0] rob_new_pc;

    modport master (
        input  instr_issued, predict_pc, mem_done, mem_data, rob_clear, rob_new_pc,
        output instr_ready, instr_in, instr_addr_in, mem_req, mem_addr
    );

    modport slave (
        output instr_issued, predict_pc, mem_done, mem_data, rob_clear, rob_new_pc,
        input  instr_ready, instr_in, instr_addr_in, mem_req, mem_addr
    );
endinterface

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - PC holder and instruction fetch front-end with direct-mapped I-cache
module instr_fetcher #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    instr_fetcher_if.master   bus
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ready_q, ready_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        req_q, req_d;
    logic [31:0] maddr_q, maddr_d;
    logic        fill;

    logic [LINES-1:0] line_valid;
    logic [TAG_W-1:0] line_tag  [LINES];
    logic [31:0]      line_data [LINES];

    logic [31:0]             pred_pc;
    logic [ICACHE_IDX_W-1:0] pc_idx, pred_idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, pred_tag, fill_tag;
    logic                    pc_hit, pred_hit;

    // Low address bits are dropped so every stored PC is word aligned.
    assign pred_pc  = bus.predict_pc & ~32'h3;
    assign pc_idx   = pc_q[ICACHE_IDX_W+1:2];
    assign pc_tag   = pc_q[31:ICACHE_IDX_W+2];
    assign pred_idx = pred_pc[ICACHE_IDX_W+1:2];
    assign pred_tag = pred_pc[31:ICACHE_IDX_W+2];
    assign fill_idx = maddr_q[ICACHE_IDX_W+1:2];
    assign fill_tag = maddr_q[31:ICACHE_IDX_W+2];

    assign pc_hit   = line_valid[pc_idx]   && (line_tag[pc_idx]   == pc_tag);
    assign pred_hit = line_valid[pred_idx] && (line_tag[pred_idx] == pred_tag);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ready_d = ready_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        req_d   = req_q;
        maddr_d = maddr_q;
        fill    = 1'b0;
        if (rdy) begin
            if (bus.rob_clear) begin
                pc_d    = bus.rob_new_pc & ~32'h3;
                ready_d = 1'b0;
                case (state_q)
                    WAIT_MEM, DROP: begin
                        // An in-flight fetch still fills the cache but is never presented.
                        if (bus.mem_done) begin
                            fill    = 1'b1;
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pc_hit) begin
                            ready_d = 1'b1;
                            instr_d = line_data[pc_idx];
                            iaddr_d = pc_q;
                            state_d = HOLD;
                        end else begin
                            req_d   = 1'b1;
                            maddr_d = pc_q;
                            state_d = WAIT_MEM;
                        end
                    end
                    WAIT_MEM: begin
                        if (bus.mem_done) begin
                            fill    = 1'b1;
                            req_d   = 1'b0;
                            ready_d = 1'b1;
                            instr_d = bus.mem_data;
                            iaddr_d = pc_q;
                            state_d = HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.instr_issued) begin
                            pc_d = pred_pc;
                            if (pred_hit) begin
                                ready_d = 1'b1;
                                instr_d = line_data[pred_idx];
                                iaddr_d = pred_pc;
                            end else begin
                                ready_d = 1'b0;
                                req_d   = 1'b1;
                                maddr_d = pred_pc;
                                state_d = WAIT_MEM;
                            end
                        end
                    end
                    DROP: begin
                        if (bus.mem_done) begin
                            fill    = 1'b1;
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ready_q    <= 1'b0;
            instr_q    <= 32'h0;
            iaddr_q    <= 32'h0;
            req_q      <= 1'b0;
            maddr_q    <= 32'h0;
            line_valid <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            if (fill) begin
                line_valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && fill) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= bus.mem_data;
        end
    end

    assign bus.instr_ready   = ready_q;
    assign bus.instr_in      = instr_q;
    assign bus.instr_addr_in = iaddr_q;
    assign bus.mem_req       = req_q;
    assign bus.mem_addr      = maddr_q;
endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - directed vector table plus hand sequences for instr_fetcher
module tb_instr_fetcher;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    instr_fetcher_if bus();

    instr_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        iss;
        logic [31:0] ppc;
        logic        done;
        logic [31:0] mdata;
        logic        clr;
        logic [31:0] npc;
        logic        e_ready;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_req;
        logic [31:0] e_maddr;
    } vec_t;

    localparam logic [31:0] W0   = 32'h0000_0013;
    localparam logic [31:0] W4   = 32'h0040_0093;
    localparam logic [31:0] W8   = 32'hDEAD_0008;
    localparam logic [31:0] W100 = 32'h1110_0013;

    int n_assert = 0;
    int n_fail   = 0;
    vec_t tbl [27];

    function automatic vec_t mk(input logic r, input logic iss, input logic [31:0] ppc,
                                input logic done, input logic [31:0] md,
                                input logic clr, input logic [31:0] npc,
                                input logic er, input logic [31:0] ei, input logic [31:0] ea,
                                input logic eq, input logic [31:0] em);
        vec_t v;
        v.rst = r;   v.rdy = 1'b1; v.iss = iss; v.ppc = ppc;
        v.done = done; v.mdata = md; v.clr = clr; v.npc = npc;
        v.e_ready = er; v.e_instr = ei; v.e_addr = ea; v.e_req = eq; v.e_maddr = em;
        return v;
    endfunction

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_req) break;
            tick();
        end
        chk({name, "_req_seen"}, 32'(bus.mem_req), 32'd1);
    endtask

    task automatic serve(input string name, input logic [31:0] a, input logic [31:0] d, input int delay);
        wait_req(name);
        chk({name, "_maddr"}, bus.mem_addr, a);
        for (int k = 0; k < delay; k++) begin
            tick();
            chk({name, "_req_hold"}, 32'(bus.mem_req), 32'd1);
            chk({name, "_maddr_hold"}, bus.mem_addr, a);
        end
        bus.mem_done = 1'b1;
        bus.mem_data = d;
        tick();
        bus.mem_done = 1'b0;
        chk({name, "_ready"}, 32'(bus.instr_ready), 32'd1);
        chk({name, "_instr"}, bus.instr_in, d);
        chk({name, "_iaddr"}, bus.instr_addr_in, a);
        chk({name, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    endtask

    task automatic issue(input logic [31:0] p);
        bus.instr_issued = 1'b1;
        bus.predict_pc   = p;
        tick();
        bus.instr_issued = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        bus.instr_issued = 1'b0; bus.predict_pc = 32'h0;
        bus.mem_done = 1'b0; bus.mem_data = 32'h0;
        bus.rob_clear = 1'b0; bus.rob_new_pc = 32'h0;

        // Reset, first miss to 0, fill 0x4, then ping-pong hits, hold, miss, flush, redirects.
        tbl[0]  = mk(0, 0, 0,     0, 0,    0, 0,     0, 0,    0,     0, 0);
        tbl[1]  = mk(0, 0, 0,     0, 0,    0, 0,     0, 0,    0,     0, 0);
        tbl[2]  = mk(1, 0, 0,     0, 0,    0, 0,     0, 0,    0,     1, 0);
        tbl[3]  = mk(1, 0, 0,     0, 0,    0, 0,     0, 0,    0,     1, 0);
        tbl[4]  = mk(1, 0, 0,     0, 0,    0, 0,     0, 0,    0,     1, 0);
        tbl[5]  = mk(1, 0, 0,     1, W0,   0, 0,     1, W0,   0,     0, 0);
        tbl[6]  = mk(1, 1, 4,     0, 0,    0, 0,     0, W0,   0,     1, 4);
        tbl[7]  = mk(1, 0, 0,     1, W4,   0, 0,     1, W4,   4,     0, 4);
        tbl[8]  = mk(1, 1, 0,     0, 0,    0, 0,     1, W0,   0,     0, 4);
        tbl[9]  = mk(1, 1, 4,     0, 0,    0, 0,     1, W4,   4,     0, 4);
        tbl[10] = mk(1, 1, 0,     0, 0,    0, 0,     1, W0,   0,     0, 4);
        tbl[11] = mk(1, 1, 4,     0, 0,    0, 0,     1, W4,   4,     0, 4);
        for (int i = 12; i < 17; i++)
            tbl[i] = mk(1, 0, 0,  0, 0,    0, 0,     1, W4,   4,     0, 4);
        tbl[17] = mk(1, 1, 8,     0, 0,    0, 0,     0, W4,   4,     1, 8);
        tbl[18] = mk(1, 0, 0,     0, 0,    0, 0,     0, W4,   4,     1, 8);
        tbl[19] = mk(1, 0, 0,     0, 0,    1, 32'h100, 0, W4, 4,     1, 8);
        tbl[20] = mk(1, 0, 0,     0, 0,    0, 0,     0, W4,   4,     1, 8);
        tbl[21] = mk(1, 0, 0,     1, W8,   0, 0,     0, W4,   4,     0, 8);
        tbl[22] = mk(1, 0, 0,     0, 0,    0, 0,     0, W4,   4,     1, 32'h100);
        tbl[23] = mk(1, 0, 0,     1, W100, 0, 0,     1, W100, 32'h100, 0, 32'h100);
        tbl[24] = mk(1, 1, 8,     0, 0,    0, 0,     1, W8,   8,     0, 32'h100);
        tbl[25] = mk(1, 1, 32'h100, 0, 0,  1, 4,     0, W8,   8,     0, 32'h100);
        tbl[26] = mk(1, 0, 0,     0, 0,    0, 0,     1, W4,   4,     0, 32'h100);

        for (int i = 0; i < 27; i++) begin
            rst              = tbl[i].rst;
            rdy              = tbl[i].rdy;
            bus.instr_issued = tbl[i].iss;
            bus.predict_pc   = tbl[i].ppc;
            bus.mem_done     = tbl[i].done;
            bus.mem_data     = tbl[i].mdata;
            bus.rob_clear    = tbl[i].clr;
            bus.rob_new_pc   = tbl[i].npc;
            tick();
            chk($sformatf("v%0d_ready", i), 32'(bus.instr_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_instr", i), bus.instr_in,         tbl[i].e_instr);
            chk($sformatf("v%0d_iaddr", i), bus.instr_addr_in,    tbl[i].e_addr);
            chk($sformatf("v%0d_req", i),   32'(bus.mem_req),     32'(tbl[i].e_req));
            chk($sformatf("v%0d_maddr", i), bus.mem_addr,         tbl[i].e_maddr);
        end
        bus.instr_issued = 1'b0; bus.mem_done = 1'b0; bus.rob_clear = 1'b0;

        // Same-index aliasing: 0x0, 0x40, 0x0 all miss.
        rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
        serve("alias0", 32'h0, mw(32'h0), 2);
        issue(32'h40);
        chk("alias40_miss", 32'(bus.mem_req), 32'd1);
        serve("alias40", 32'h40, mw(32'h40), 1);
        issue(32'h0);
        chk("alias0b_miss", 32'(bus.mem_req), 32'd1);
        serve("alias0b", 32'h0, mw(32'h0), 0);

        // Freeze mid-WAIT_MEM: a redirect offered while rdy=0 must be ignored.
        issue(32'h8);
        chk("frz_req", 32'(bus.mem_req), 32'd1);
        rdy = 1'b0; bus.rob_clear = 1'b1; bus.rob_new_pc = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("frz_req_hold", 32'(bus.mem_req), 32'd1);
            chk("frz_maddr",    bus.mem_addr, 32'h8);
            chk("frz_ready",    32'(bus.instr_ready), 32'd0);
        end
        rdy = 1'b1; bus.rob_clear = 1'b0;
        serve("frz_fill", 32'h8, mw(32'h8), 1);

        // Reset mid-HOLD clears outputs and invalidates line 0 (which held 0x0).
        rst = 1'b0; tick();
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_instr", bus.instr_in, 32'h0);
        chk("rst_iaddr", bus.instr_addr_in, 32'h0);
        chk("rst_req",   32'(bus.mem_req), 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'h0);
        rst = 1'b1; tick();
        chk("rst_inval_req",   32'(bus.mem_req), 32'd1);
        chk("rst_inval_maddr", bus.mem_addr, 32'h0);
        serve("rst_refill", 32'h0, mw(32'h0), 0);

        // Flush coinciding with mem_done: fills the line, never presented, then hits.
        issue(32'h40);
        chk("co_req",   32'(bus.mem_req), 32'd1);
        chk("co_maddr", bus.mem_addr, 32'h40);
        bus.mem_done = 1'b1; bus.mem_data = mw(32'h40);
        bus.rob_clear = 1'b1; bus.rob_new_pc = 32'h40;
        tick();
        bus.mem_done = 1'b0; bus.rob_clear = 1'b0;
        chk("co_ready0", 32'(bus.instr_ready), 32'd0);
        chk("co_req0",   32'(bus.mem_req), 32'd0);
        tick();
        chk("co_hit_ready", 32'(bus.instr_ready), 32'd1);
        chk("co_hit_instr", bus.instr_in, mw(32'h40));
        chk("co_hit_iaddr", bus.instr_addr_in, 32'h40);
        chk("co_hit_req",   32'(bus.mem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
